ecap5_wb_ram: RTL and testbench

- Wishbone B4 pipelined responder (slave) backed by a single-port word RAM; the memory-side counterpart of the ecap5_dproc Wishbone master port.
- Used as instruction/data memory in core-level benches and FPGA builds.
- Fixed-latency, in-order responses with at most one response per cycle.
- Partial-word writes are read-modify-write on the single-port array and stall the bus for one cycle.

---
 rtl/ecap5_dproc_pkg.sv | 34 +++
 rtl/ecap5_wb_resp_pipe.sv | 37 +++
 rtl/ecap5_wb_ram.sv | 137 +++++++++++++
 tb/tb_ecap5_wb_ram.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types and helpers for the ecap5 Wishbone memory responder.
package ecap5_dproc_pkg;

    // Responder FSM: IDLE accepts requests, RMW finishes a partial-word write.
    typedef enum logic {
        IDLE,
        RMW
    } wb_ram_state_t;

    // Byte-lane mask that selects the whole 32-bit word.
    localparam logic [3:0] WB_SEL_WORD = 4'hF;

    // One queued bus response; data is only meaningful for read acks.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } wb_resp_t;

    // Replace the byte lanes of old_word selected by sel with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ecap5_wb_resp_pipe.sv
// Fixed-latency response delay line: one entry enters per clock and leaves
// LATENCY clocks later. A flush drops everything in flight.
module ecap5_wb_resp_pipe
    import ecap5_dproc_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  wb_resp_t push_entry,
    output wb_resp_t head_entry
);

    wb_resp_t stages [LATENCY];

    // Shift entries toward the head every cycle; flush and reset clear all stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= push_entry;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign head_entry = stages[LATENCY-1];

endmodule

// File: rtl/ecap5_wb_ram.sv
// Wishbone B4 pipelined responder over a single-port 32-bit word RAM.
// Fixed-latency, in-order responses; partial-word writes take one extra
// stalled cycle for the read-modify-write.
module ecap5_wb_ram
    import ecap5_dproc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    wb_ram_state_t         state;
    logic [ADDR_WIDTH-1:0] rmw_idx;
    logic [31:0]           rmw_old;
    logic [31:0]           rmw_dat;
    logic [3:0]            rmw_sel;

    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  full_write;
    logic                  partial_write;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [31:0]           mem_wdata;
    wb_resp_t              push_entry;
    wb_resp_t              head_entry;

    // Request decode and acceptance; stall is only ever caused by RMW.
    always_comb begin
        wb_stall_o    = (state == RMW);
        accept        = wb_cyc_i & wb_stb_i & ~wb_stall_o;
        word_idx      = wb_adr_i[ADDR_WIDTH+1:2];
        in_range      = ((wb_adr_i >> (ADDR_WIDTH + 2)) == '0);
        full_write    = accept & wb_we_i & in_range & (wb_sel_i == WB_SEL_WORD);
        partial_write = accept & wb_we_i & in_range &
                        (wb_sel_i != WB_SEL_WORD) & (wb_sel_i != 4'h0);
    end

    // Single write port: the RMW merge and full writes never coincide because
    // nothing is accepted while in RMW. Reset blocks any pending merge.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = word_idx;
        mem_wdata = wb_dat_i;
        if (state == RMW) begin
            mem_we    = ~rst_i;
            mem_idx   = rmw_idx;
            mem_wdata = merge_bytes(rmw_old, rmw_dat, rmw_sel);
        end else if (full_write) begin
            mem_we = ~rst_i;
        end
    end

    // RAM write port; contents are never cleared by reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // RMW FSM: latch the old word and write data on accept, commit on exit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rmw_idx <= '0;
            rmw_old <= '0;
            rmw_dat <= '0;
            rmw_sel <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (partial_write) begin
                        state   <= RMW;
                        rmw_idx <= word_idx;
                        rmw_old <= mem[word_idx];
                        rmw_dat <= wb_dat_i;
                        rmw_sel <= wb_sel_i;
                    end
                end
                RMW: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Build the response for the request accepted this cycle.
    always_comb begin
        push_entry = '0;
        if (accept) begin
            push_entry.valid = 1'b1;
            push_entry.err   = ~in_range;
            if (in_range && !wb_we_i) begin
                push_entry.data = mem[word_idx];
            end
        end
    end

    ecap5_wb_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (~wb_cyc_i),
        .push_entry (push_entry),
        .head_entry (head_entry)
    );

    // Drive the bus from the pipeline head; data only accompanies an ack.
    always_comb begin
        wb_ack_o = head_entry.valid & ~head_entry.err;
        wb_err_o = head_entry.valid & head_entry.err;
        wb_dat_o = wb_ack_o ? head_entry.data : 32'h0;
    end

endmodule

// File: tb/tb_ecap5_wb_ram.sv
// Bench for ecap5_wb_ram: two instances (LATENCY 1 and 3) share one stimulus
// stream; each has its own queue of expected responses.
module tb_ecap5_wb_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat_w = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;

    logic [31:0] dat1, dat3;
    logic        ack1, err1, stall1;
    logic        ack3, err3, stall3;

    always #5 clk = ~clk;

    ecap5_wb_ram #(.ADDR_WIDTH(10), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat1),
        .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack1), .wb_err_o(err1), .wb_stall_o(stall1)
    );

    ecap5_wb_ram #(.ADDR_WIDTH(10), .LATENCY(3), .INIT_FILE("")) dut3 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat3),
        .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack3), .wb_err_o(err3), .wb_stall_o(stall3)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    vec_t vecs[$];
    exp_t q1[$];
    exp_t q3[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_n = 0;
    logic        m_rmw = 1'b0;
    logic        last_acc = 1'b0;
    logic        cur_err = 1'b0;
    logic [31:0] cur_dat = '0;

    task automatic cmp(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
        end
    endtask

    // Advance one clock: update the reference model at the edge, then compare
    // both DUTs 1ns later.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        exp_t        e;
        logic [33:0] x;
        @(posedge clk);
        cyc_n++;
        acc = 1'b0;
        if (rst) begin
            q1.delete();
            q3.delete();
            m_rmw = 1'b0;
        end else begin
            acc   = cyc && stb && !m_rmw;
            m_rmw = 1'b0;
            if (!cyc) begin
                q1.delete();
                q3.delete();
            end
            if (acc) begin
                a     = adr;
                e.err = cur_err;
                e.dat = cur_err ? 32'h0 : cur_dat;
                e.due = cyc_n;
                q1.push_back(e);
                e.due = cyc_n + 2;
                q3.push_back(e);
                if (we && a[31:12] == 20'h0 && sel != 4'h0 && sel != 4'hF) m_rmw = 1'b1;
            end
        end
        last_acc = acc;
        #1;
        x = '0;
        if (q1.size() > 0 && q1[0].due == cyc_n) begin
            x = {~q1[0].err, q1[0].err, q1[0].dat};
            void'(q1.pop_front());
        end
        cmp("resp_lat1", {ack1, err1, dat1}, x);
        x = '0;
        if (q3.size() > 0 && q3[0].due == cyc_n) begin
            x = {~q3[0].err, q3[0].err, q3[0].dat};
            void'(q3.pop_front());
        end
        cmp("resp_lat3", {ack3, err3, dat3}, x);
        cmp("stall_lat1", {33'h0, stall1}, {33'h0, m_rmw});
        cmp("stall_lat3", {33'h0, stall3}, {33'h0, m_rmw});
    endtask

    // Present one request and hold it until the model says it is accepted.
    task automatic req(input logic w, input logic [31:0] ad, input logic [31:0] d,
                       input logic [3:0] s, input logic ee, input logic [31:0] ed);
        cyc = 1'b1; stb = 1'b1; we = w; adr = ad; dat_w = d; sel = s;
        cur_err = ee; cur_dat = ed;
        for (int t = 0; t < 4; t++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_accept adr %h: not accepted within 4 cycles", ad);
        end
        stb = 1'b0;
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        // we, adr, dat, sel, exp_err, exp_dat
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 32'h11BB_33DD});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1002, 32'h1234_5678, 4'h3, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h0BAD_F00D});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'h4444_4444, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0008, 32'h8888_8888, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_000C, 32'hCCCC_CCCC, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'h1234_5678, 4'h0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h0BAD_F00D});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'hF, 1'b0, 32'h4444_4444});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         4'hF, 1'b0, 32'h8888_8888});
        vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,         4'hF, 1'b0, 32'hCCCC_CCCC});
        vecs.push_back('{1'b1, 32'h0000_0008, 32'h00AB_0000, 4'h4, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         4'hF, 1'b0, 32'h88AB_8888});
        vecs.push_back('{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'h8, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,         4'hF, 1'b0, 32'hFFCC_CCCC});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b0, 32'hA5A5_A5A5});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF});

        // Reset state with the clock running.
        step();
        step();
        rst = 1'b0;
        cyc = 1'b1;
        idle(1);

        // Table of back-to-back requests.
        for (int i = 0; i < vecs.size(); i++) begin
            req(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                vecs[i].exp_err, vecs[i].exp_dat);
        end
        idle(5);

        // Abort: two reads in flight, then cyc drops; LATENCY=3 must never respond.
        req(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D);
        req(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h4444_4444);
        cyc = 1'b0;
        step();
        // Strobe without cyc is ignored.
        stb = 1'b1; adr = 32'h10; we = 1'b0;
        step();
        step();
        stb = 1'b0;
        cyc = 1'b1;
        step();
        req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
        idle(5);

        // Asynchronous reset while in RMW: merge is dropped, word keeps old value.
        req(1'b1, 32'h30, 32'h0102_0304, 4'hF, 1'b0, 32'h0);
        req(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h1, 1'b0, 32'h0);
        #3;
        rst = 1'b1;
        #1;
        m_rmw = 1'b0;
        q1.delete();
        q3.delete();
        cmp("async_rst_lat1", {ack1, err1, dat1}, 34'h0);
        cmp("async_rst_lat3", {ack3, err3, dat3}, 34'h0);
        cmp("async_rst_stall1", {33'h0, stall1}, 34'h0);
        cmp("async_rst_stall3", {33'h0, stall3}, 34'h0);
        step();
        rst = 1'b0;
        req(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 32'h0102_0304);
        req(1'b1, 32'h30, 32'h0000_00EE, 4'h1, 1'b0, 32'h0);
        req(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 32'h0102_03EE);
        idle(5);

        n_checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d/%0d responses still expected", q1.size(), q3.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
